centroid_tracker: RTL and testbench

- Consumes the per-pixel mask stream (hcount/vcount plus a "pixel selected" bit) from the camera/threshold pipeline.
- Accumulates the selected pixels' x and y sums and count across one frame.
- At each new-frame pulse, divides sums by count and emits one (x, y) position per frame.
- Output feeds the frame-rate position inputs of the saber trail renderer. Same nf semantics: one update per frame.

---
 rtl/centroid_pkg.sv | 15 +
 rtl/centroid_tracker_seq_divider.sv | 75 +++++++
 rtl/centroid_tracker.sv | 169 ++++++++++++++++
 tb/tb_centroid_tracker.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/centroid_pkg.sv
// centroid_pkg: shared widths and FSM state type for the centroid tracker.
// Exports SUM_W, CNT_W, DIV_ITERS and state_t.
package centroid_pkg;

    localparam int SUM_W     = 32;
    localparam int CNT_W     = 20;
    localparam int DIV_ITERS = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIVIDE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/centroid_tracker_seq_divider.sv
// seq_divider: restoring unsigned divider, one quotient bit per cycle,
// fixed DIV_ITERS-cycle latency from start to done.
// Ports: clk_in, rst_n_in (async active-low), start, dividend, divisor,
//        busy (iterating), done (1-cycle pulse, quotient valid),
//        quotient (low QUOTIENT_W bits of the full quotient).
module seq_divider
    import centroid_pkg::*;
#(
    parameter int DIVIDEND_W = 32,
    parameter int DIVISOR_W  = 20,
    parameter int QUOTIENT_W = 11
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [QUOTIENT_W-1:0] quotient
);

    localparam int IW = $clog2(DIV_ITERS);

    // quo_q starts as the dividend and is shifted out MSB-first while
    // quotient bits are shifted in at the bottom.
    logic [DIVIDEND_W-1:0] quo_q;
    logic [DIVISOR_W-1:0]  rem_q;
    logic [DIVISOR_W-1:0]  dsr_q;
    logic [IW-1:0]         iter_q;

    logic [DIVISOR_W:0]    rem_sh;
    logic [DIVISOR_W:0]    rem_sub;
    logic                  fits;
    logic [DIVISOR_W-1:0]  rem_nxt;

    always_comb begin
        rem_sh  = {rem_q, quo_q[DIVIDEND_W-1]};
        rem_sub = rem_sh - {1'b0, dsr_q};
        fits    = rem_sh >= {1'b0, dsr_q};
        // Partial remainder stays below the divisor, so it fits DIVISOR_W.
        rem_nxt = DIVISOR_W'(fits ? rem_sub : rem_sh);
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            quo_q  <= '0;
            rem_q  <= '0;
            dsr_q  <= '0;
            iter_q <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start && !busy) begin
                quo_q  <= dividend;
                rem_q  <= '0;
                dsr_q  <= divisor;
                iter_q <= '0;
                busy   <= 1'b1;
            end else if (busy) begin
                quo_q  <= {quo_q[DIVIDEND_W-2:0], fits};
                rem_q  <= rem_nxt;
                iter_q <= iter_q + IW'(1);
                if (iter_q == IW'(DIV_ITERS - 1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    assign quotient = quo_q[QUOTIENT_W-1:0];

endmodule

// File: rtl/centroid_tracker.sv
// centroid_tracker: accumulates selected-pixel x/y sums over a frame and
// emits the floor centroid once per frame, 34 cycles after nf_in.
// Ports: clk_in, rst_n_in (async active-low), hcount_in, vcount_in,
//        valid_in, mask_in, nf_in (new-frame pulse); x_out, y_out (held),
//        valid_out (update pulse), locked_out, drop_out (discard pulse).
// Option: define CENTROID_IIR_EN for 1/4-gain smoothing of locked results.
module centroid_tracker
    import centroid_pkg::*;
#(
    parameter int H_ACTIVE  = 1280,
    parameter int V_ACTIVE  = 720,
    parameter int MIN_COUNT = 16
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic        valid_in,
    input  logic        mask_in,
    input  logic        nf_in,
    output logic [10:0] x_out,
    output logic [9:0]  y_out,
    output logic        valid_out,
    output logic        locked_out,
    output logic        drop_out
);

    logic [SUM_W-1:0] sum_x_q;
    logic [SUM_W-1:0] sum_y_q;
    logic [CNT_W-1:0] count_q;
    state_t           state_q;
    logic             lock_pend_q;

    logic             pix_hit;
    logic             frame_ok;
    logic             div_start;
    logic             busy_x, busy_y;
    logic             done_x, done_y;
    logic [10:0]      quo_x;
    logic [9:0]       quo_y;
    logic [10:0]      x_nxt;
    logic [9:0]       y_nxt;

    always_comb begin
        pix_hit = valid_in && mask_in
               && (hcount_in < 11'(H_ACTIVE))
               && (vcount_in < 10'(V_ACTIVE));
        frame_ok = (count_q >= CNT_W'(MIN_COUNT)) && (count_q != '0);
        div_start = nf_in && (state_q == ST_IDLE) && frame_ok
                 && !busy_x && !busy_y;
    end

    // A pixel arriving with nf_in opens the new frame.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            sum_x_q <= '0;
            sum_y_q <= '0;
            count_q <= '0;
        end else if (nf_in) begin
            sum_x_q <= pix_hit ? SUM_W'(hcount_in) : '0;
            sum_y_q <= pix_hit ? SUM_W'(vcount_in) : '0;
            count_q <= pix_hit ? CNT_W'(1) : '0;
        end else if (pix_hit) begin
            sum_x_q <= sum_x_q + SUM_W'(hcount_in);
            sum_y_q <= sum_y_q + SUM_W'(vcount_in);
            count_q <= count_q + CNT_W'(1);
        end
    end

    // The dividers' operand registers hold the frame snapshot.
    seq_divider #(
        .DIVIDEND_W (SUM_W),
        .DIVISOR_W  (CNT_W),
        .QUOTIENT_W (11)
    ) u_div_x (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .start    (div_start),
        .dividend (sum_x_q),
        .divisor  (count_q),
        .busy     (busy_x),
        .done     (done_x),
        .quotient (quo_x)
    );

    seq_divider #(
        .DIVIDEND_W (SUM_W),
        .DIVISOR_W  (CNT_W),
        .QUOTIENT_W (10)
    ) u_div_y (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .start    (div_start),
        .dividend (sum_y_q),
        .divisor  (count_q),
        .busy     (busy_y),
        .done     (done_y),
        .quotient (quo_y)
    );

`ifdef CENTROID_IIR_EN
    logic signed [12:0] dx, dy;
    logic signed [12:0] step_x, step_y;
    logic signed [12:0] sm_x, sm_y;

    always_comb begin
        dx     = $signed({2'b00, quo_x}) - $signed({2'b00, x_out});
        dy     = $signed({3'b000, quo_y}) - $signed({3'b000, y_out});
        step_x = dx >>> 2;
        step_y = dy >>> 2;
        sm_x   = $signed({2'b00, x_out}) + step_x;
        sm_y   = $signed({3'b000, y_out}) + step_y;
        // Re-acquisition after an unlocked frame snaps to the raw centroid.
        if (locked_out) begin
            x_nxt = 11'(sm_x);
            y_nxt = 10'(sm_y);
        end else begin
            x_nxt = quo_x;
            y_nxt = quo_y;
        end
    end
`else
    always_comb begin
        x_nxt = quo_x;
        y_nxt = quo_y;
    end
`endif

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q     <= ST_IDLE;
            lock_pend_q <= 1'b0;
            x_out       <= '0;
            y_out       <= '0;
            valid_out   <= 1'b0;
            locked_out  <= 1'b0;
            drop_out    <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            drop_out  <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (nf_in) begin
                        lock_pend_q <= div_start;
                        state_q     <= div_start ? ST_DIVIDE : ST_DONE;
                    end
                end
                ST_DIVIDE: begin
                    if (nf_in) drop_out <= 1'b1;
                    if (done_x && done_y) state_q <= ST_DONE;
                end
                ST_DONE: begin
                    if (nf_in) drop_out <= 1'b1;
                    state_q <= ST_IDLE;
                    if (lock_pend_q) begin
                        x_out      <= x_nxt;
                        y_out      <= y_nxt;
                        valid_out  <= 1'b1;
                        locked_out <= 1'b1;
                    end else begin
                        locked_out <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_centroid_tracker.sv
// tb_centroid_tracker: directed and random frames for centroid_tracker,
// checked against a per-frame pixel-list reference model.
module tb_centroid_tracker;

    logic        clk_in = 1'b0;
    logic        rst_n_in = 1'b0;
    logic [10:0] hcount_in = '0;
    logic [9:0]  vcount_in = '0;
    logic        valid_in = 1'b0;
    logic        mask_in = 1'b0;
    logic        nf_in = 1'b0;
    logic [10:0] x_out;
    logic [9:0]  y_out;
    logic        valid_out;
    logic        locked_out;
    logic        drop_out;

    centroid_tracker dut (
        .clk_in     (clk_in),
        .rst_n_in   (rst_n_in),
        .hcount_in  (hcount_in),
        .vcount_in  (vcount_in),
        .valid_in   (valid_in),
        .mask_in    (mask_in),
        .nf_in      (nf_in),
        .x_out      (x_out),
        .y_out      (y_out),
        .valid_out  (valid_out),
        .locked_out (locked_out),
        .drop_out   (drop_out)
    );

    always #5 clk_in = ~clk_in;

`ifdef CENTROID_IIR_EN
    localparam bit IIR_EN = 1'b1;
`else
    localparam bit IIR_EN = 1'b0;
`endif

    typedef struct {
        int x;
        int y;
    } pix_t;

    int   n_vec = 0;
    int   n_err = 0;
    pix_t acc[$];
    int   m_x = 0;
    int   m_y = 0;
    bit   m_locked = 1'b0;
    bit   exp_valid = 1'b0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int floor_div4(int d);
        return (d >= 0) ? d / 4 : -((-d + 3) / 4);
    endfunction

    function automatic bit counts(int x, int y, bit v, bit m);
        return v && m && x < 1280 && y < 720;
    endfunction

    // Close the current frame; an accepted frame updates the held outputs.
    task automatic model_nf(bit accepted);
        longint sx = 0;
        longint sy = 0;
        int     c  = acc.size();
        int     qx, qy;
        foreach (acc[i]) begin
            sx += acc[i].x;
            sy += acc[i].y;
        end
        if (accepted) begin
            if (c >= 16) begin
                qx = int'(sx / c);
                qy = int'(sy / c);
                if (IIR_EN && m_locked) begin
                    m_x = m_x + floor_div4(qx - m_x);
                    m_y = m_y + floor_div4(qy - m_y);
                end else begin
                    m_x = qx;
                    m_y = qy;
                end
                m_locked  = 1'b1;
                exp_valid = 1'b1;
            end else begin
                m_locked  = 1'b0;
                exp_valid = 1'b0;
            end
        end
        acc.delete();
    endtask

    task automatic px(int x, int y, bit v, bit m);
        @(negedge clk_in);
        hcount_in = 11'(x);
        vcount_in = 10'(y);
        valid_in  = v;
        mask_in   = m;
        nf_in     = 1'b0;
        if (counts(x, y, v, m)) acc.push_back('{x, y});
    endtask

    task automatic pulse_nf(int x, int y, bit v, bit m);
        @(negedge clk_in);
        hcount_in = 11'(x);
        vcount_in = 10'(y);
        valid_in  = v;
        mask_in   = m;
        nf_in     = 1'b1;
        model_nf(1'b1);
        if (counts(x, y, v, m)) acc.push_back('{x, y});
        @(negedge clk_in);
        nf_in    = 1'b0;
        valid_in = 1'b0;
        mask_in  = 1'b0;
    endtask

    // Called right after pulse_nf; optional second nf lands at edge N+drop_at.
    task automatic check_result(string tag, int drop_at);
        int early = 0;
        int drops = 0;
        for (int k = 1; k <= 33; k++) begin
            @(negedge clk_in);
            if (valid_out) early++;
            if (drop_out) drops++;
            if (drop_at != 0 && k == drop_at) begin
                nf_in = 1'b0;
                chk({tag, " drop pulse"}, 32'(drop_out), 32'd1);
            end
            if (drop_at != 0 && k == drop_at - 1) begin
                nf_in = 1'b1;
                model_nf(1'b0);
            end
        end
        @(negedge clk_in);
        chk({tag, " valid@34"}, 32'(valid_out), 32'(exp_valid));
        chk({tag, " x"}, 32'(x_out), m_x);
        chk({tag, " y"}, 32'(y_out), m_y);
        chk({tag, " locked"}, 32'(locked_out), 32'(m_locked));
        @(negedge clk_in);
        chk({tag, " valid@35"}, 32'(valid_out), 32'd0);
        chk({tag, " early valid"}, early, 0);
        chk({tag, " drops"}, drops, (drop_at != 0) ? 1 : 0);
    endtask

    initial begin
        int n, cx, cy, early;

        // Reset state
        repeat (3) @(negedge clk_in);
        chk("rst x", 32'(x_out), 0);
        chk("rst y", 32'(y_out), 0);
        chk("rst valid", 32'(valid_out), 0);
        chk("rst locked", 32'(locked_out), 0);
        chk("rst drop", 32'(drop_out), 0);
        rst_n_in = 1'b1;
        repeat (2) @(negedge clk_in);

        // 4x4 block -> (101, 51)
        for (int y = 50; y <= 53; y++)
            for (int x = 100; x <= 103; x++)
                px(x, y, 1'b1, 1'b1);
        pulse_nf(0, 0, 1'b0, 1'b0);
        check_result("block", 0);

        // 10 pixels only; nf carries pixel (640,360) into the next frame
        repeat (10) px(500, 300, 1'b1, 1'b1);
        pulse_nf(640, 360, 1'b1, 1'b1);
        check_result("unlock", 0);

        repeat (15) px(640, 360, 1'b1, 1'b1);
        pulse_nf(0, 0, 1'b0, 1'b0);
        check_result("nfpix", 0);

        // Out-of-range and invalid pixels are ignored
        px(1280, 10, 1'b1, 1'b1);
        px(10, 720, 1'b1, 1'b1);
        px(2000, 1000, 1'b1, 1'b1);
        px(700, 700, 1'b0, 1'b1);
        repeat (16) px(0, 0, 1'b1, 1'b1);
        pulse_nf(0, 0, 1'b0, 1'b0);
        check_result("range", 0);

        // Second nf 10 cycles after the first is dropped
        cx = $urandom_range(0, 1200);
        cy = $urandom_range(0, 650);
        for (int i = 0; i < 24; i++)
            px(cx + $urandom_range(0, 30), cy + $urandom_range(0, 30),
               1'b1, 1'b1);
        pulse_nf(0, 0, 1'b0, 1'b0);
        check_result("drop", 10);

        // Random frames, some below MIN_COUNT or partly out of range
        for (int r = 0; r < 8; r++) begin
            n  = $urandom_range(0, 40);
            cx = $urandom_range(0, 1279);
            cy = $urandom_range(0, 719);
            for (int i = 0; i < n; i++)
                px(cx + $urandom_range(0, 15), cy + $urandom_range(0, 15),
                   $urandom_range(0, 9) != 0, $urandom_range(0, 4) != 0);
            pulse_nf(cx, cy, $urandom_range(0, 1) == 1, 1'b1);
            check_result("rand", 0);
        end

        // Make sure outputs are nonzero and locked before the reset test
        repeat (20) px(300, 200, 1'b1, 1'b1);
        pulse_nf(0, 0, 1'b0, 1'b0);
        check_result("prerst", 0);

        // Reset at N+20 of a division
        repeat (20) px(900, 600, 1'b1, 1'b1);
        pulse_nf(0, 0, 1'b0, 1'b0);
        repeat (20) @(negedge clk_in);
        rst_n_in = 1'b0;
        #1;
        chk("midrst x", 32'(x_out), 0);
        chk("midrst y", 32'(y_out), 0);
        chk("midrst valid", 32'(valid_out), 0);
        chk("midrst locked", 32'(locked_out), 0);
        chk("midrst drop", 32'(drop_out), 0);
        m_x = 0;
        m_y = 0;
        m_locked = 1'b0;
        acc.delete();
        repeat (2) @(negedge clk_in);
        rst_n_in = 1'b1;
        early = 0;
        repeat (40) begin
            @(negedge clk_in);
            if (valid_out) early++;
        end
        chk("postrst valid", early, 0);
        chk("postrst x", 32'(x_out), 0);

        // Two locked frames at x=100 then x=200
        repeat (16) px(100, 40, 1'b1, 1'b1);
        pulse_nf(0, 0, 1'b0, 1'b0);
        check_result("iir1", 0);
        chk("iir1 const", 32'(x_out), 32'd100);
        repeat (16) px(200, 40, 1'b1, 1'b1);
        pulse_nf(0, 0, 1'b0, 1'b0);
        check_result("iir2", 0);
        chk("iir2 const", 32'(x_out), IIR_EN ? 32'd125 : 32'd200);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
